// File: rtl/ex_muldiv_stage_if.sv
// ID/EX -> EX/MEM bundle for the execute stage, including hazard-unit stall/busy outputs.
interface ex_muldiv_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic [3:0]       ALUselE;
  logic             ALUInSelE;
  logic             RFDSelE;
  logic             RFWEE;
  logic             DMWEE;
  logic             MtoRFSelE;
  logic             BranchE;
  logic [WIDTH-1:0] RFRD1E;
  logic [WIDTH-1:0] RFRD2E;
  logic [WIDTH-1:0] simmE;
  logic [WIDTH-1:0] PCp1E;
  logic [4:0]       rdE;
  logic [4:0]       rtE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [WIDTH-1:0] ALUOutM;
  logic [WIDTH-1:0] ResultW;

  logic [WIDTH-1:0] ALUOutE;
  logic [WIDTH-1:0] WriteDataE;
  logic [4:0]       WriteRegE;
  logic             RFWEOutE;
  logic             DMWEOutE;
  logic             MtoRFSelOutE;
  logic             BranchTakenE;
  logic [WIDTH-1:0] PCBranchE;
  logic             ZeroE;
  logic             StallE;
  logic             BusyE;

  modport slave (
    input  ALUselE, ALUInSelE, RFDSelE, RFWEE, DMWEE, MtoRFSelE, BranchE,
           RFRD1E, RFRD2E, simmE, PCp1E, rdE, rtE, ForwardAE, ForwardBE,
           ALUOutM, ResultW,
    output ALUOutE, WriteDataE, WriteRegE, RFWEOutE, DMWEOutE, MtoRFSelOutE,
           BranchTakenE, PCBranchE, ZeroE, StallE, BusyE
  );

  modport master (
    output ALUselE, ALUInSelE, RFDSelE, RFWEE, DMWEE, MtoRFSelE, BranchE,
           RFRD1E, RFRD2E, simmE, PCp1E, rdE, rtE, ForwardAE, ForwardBE,
           ALUOutM, ResultW,
    input  ALUOutE, WriteDataE, WriteRegE, RFWEOutE, DMWEOutE, MtoRFSelOutE,
           BranchTakenE, PCBranchE, ZeroE, StallE, BusyE
  );
endinterface

// File: rtl/ex_muldiv_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, branch logic and an
// iterative WIDTH-step multiply/divide unit that stalls the front end while it runs.
module ex_muldiv_stage #(
  parameter int unsigned WIDTH = 32
) (
  input logic                CLK,
  input logic                CLR,
  ex_muldiv_stage_if.slave   bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_opa;   // multiplicand (MUL) / dividend shifting into quotient (DIV/REM)
  logic [WIDTH-1:0] r_opb;   // multiplier (MUL) / divisor (DIV/REM)
  logic [WIDTH-1:0] r_acc;   // product (MUL) / partial remainder (DIV/REM)
  logic [4:0]       r_wreg;
  logic             r_rfwe;
  logic             r_dmwe;
  logic             r_mtorf;

  logic [WIDTH-1:0] w_fwd_a;
  logic [WIDTH-1:0] w_fwd_b;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_alu;
  logic [4:0]       w_wreg;
  logic             w_is_md;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_md_result;

  logic [WIDTH-1:0] w_alu_out;
  logic [4:0]       w_wreg_out;
  logic             w_rfwe_out;
  logic             w_dmwe_out;
  logic             w_mtorf_out;
  logic             w_br_en;
  logic             w_stall;
  logic             w_zero;

  // Operand forwarding; code 11 falls back to the register file value.
  always_comb begin
    w_fwd_a = bus.RFRD1E;
    w_fwd_b = bus.RFRD2E;
    case (bus.ForwardAE)
      2'b01:   w_fwd_a = bus.ResultW;
      2'b10:   w_fwd_a = bus.ALUOutM;
      default: w_fwd_a = bus.RFRD1E;
    endcase
    case (bus.ForwardBE)
      2'b01:   w_fwd_b = bus.ResultW;
      2'b10:   w_fwd_b = bus.ALUOutM;
      default: w_fwd_b = bus.RFRD2E;
    endcase
  end

  assign w_b     = bus.ALUInSelE ? bus.simmE : w_fwd_b;
  assign w_wreg  = bus.RFDSelE ? bus.rdE : bus.rtE;
  assign w_is_md = (bus.ALUselE == OP_MUL) || (bus.ALUselE == OP_DIVU) ||
                   (bus.ALUselE == OP_REMU);

  // Single-cycle ALU.
  always_comb begin
    w_alu = '0;
    case (bus.ALUselE)
      OP_AND:  w_alu = w_fwd_a & w_b;
      OP_OR:   w_alu = w_fwd_a | w_b;
      OP_ADD:  w_alu = w_fwd_a + w_b;
      OP_XOR:  w_alu = w_fwd_a ^ w_b;
      OP_NOR:  w_alu = ~(w_fwd_a | w_b);
      OP_SUB:  w_alu = w_fwd_a - w_b;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_b))};
      OP_SLL:  w_alu = w_b << bus.simmE[10:6];
      default: w_alu = '0;
    endcase
  end

  // Restoring division step; a zero divisor always "fits", giving all-ones quotient.
  assign w_rem_sh    = {r_acc, r_opa[WIDTH-1]};
  assign w_rem_diff  = w_rem_sh - {1'b0, r_opb};
  assign w_ge        = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_nxt   = WIDTH'(w_ge ? w_rem_diff : w_rem_sh);
  assign w_md_result = (r_op == OP_DIVU) ? r_opa : r_acc;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and output steering.
  always_comb begin
    w_state_nxt = r_state;
    w_alu_out   = w_alu;
    w_wreg_out  = w_wreg;
    w_rfwe_out  = bus.RFWEE;
    w_dmwe_out  = bus.DMWEE;
    w_mtorf_out = bus.MtoRFSelE;
    w_br_en     = 1'b1;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_md) begin
          w_state_nxt = S_BUSY;
          w_stall     = 1'b1;
          w_alu_out   = '0;
          w_rfwe_out  = 1'b0;
          w_dmwe_out  = 1'b0;
          w_br_en     = 1'b0;
        end
      end
      S_BUSY: begin
        if (r_cnt == CW'(WIDTH-1)) w_state_nxt = S_DONE;
        w_stall    = 1'b1;
        w_alu_out  = '0;
        w_rfwe_out = 1'b0;
        w_dmwe_out = 1'b0;
        w_br_en    = 1'b0;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_alu_out   = w_md_result;
        w_wreg_out  = r_wreg;
        w_rfwe_out  = r_rfwe;
        w_dmwe_out  = r_dmwe;
        w_mtorf_out = r_mtorf;
        w_br_en     = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Iterative unit datapath; operands are captured only on the IDLE launch edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_wreg  <= '0;
      r_rfwe  <= 1'b0;
      r_dmwe  <= 1'b0;
      r_mtorf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_md) begin
            r_cnt   <= '0;
            r_op    <= bus.ALUselE;
            r_opa   <= w_fwd_a;
            r_opb   <= w_b;
            r_acc   <= '0;
            r_wreg  <= w_wreg;
            r_rfwe  <= bus.RFWEE;
            r_dmwe  <= bus.DMWEE;
            r_mtorf <= bus.MtoRFSelE;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_op == OP_MUL) begin
            if (r_opb[0]) r_acc <= r_acc + r_opa;
            r_opa <= r_opa << 1;
            r_opb <= r_opb >> 1;
          end else begin
            r_acc <= w_rem_nxt;
            r_opa <= {r_opa[WIDTH-2:0], w_ge};
          end
        end
        default: ;
      endcase
    end
  end

  assign w_zero           = (w_alu_out == '0);
  assign bus.ALUOutE      = w_alu_out;
  assign bus.WriteDataE   = w_fwd_b;
  assign bus.WriteRegE    = w_wreg_out;
  assign bus.RFWEOutE     = w_rfwe_out;
  assign bus.DMWEOutE     = w_dmwe_out;
  assign bus.MtoRFSelOutE = w_mtorf_out;
  assign bus.ZeroE        = w_zero;
  assign bus.BranchTakenE = w_br_en & bus.BranchE & w_zero;
  assign bus.PCBranchE    = bus.PCp1E + bus.simmE;
  assign bus.StallE       = w_stall;
  assign bus.BusyE        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboard bench for ex_muldiv_stage: a driver issues directed instructions and
// queues hand-computed results; a monitor checks every non-stalled output cycle.
module tb_ex_muldiv_stage;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic tb_done = 1'b0;

  always #5 CLK = ~CLK;

  ex_muldiv_stage_if #(.WIDTH(32)) bus ();

  ex_muldiv_stage #(.WIDTH(32)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  alusel;
    logic        insel, dsel, rfwe, dmwe, mtorf, br;
    logic [31:0] rd1, rd2, simm, pcp1;
    logic [4:0]  rd, rt;
    logic [1:0]  fa, fb;
    logic [31:0] aluoutm, resultw;
  } stim_t;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [4:0]  wreg;
    logic        rfwe, dmwe, mtorf, bt;
    logic [31:0] pcb;
    logic [31:0] wdata;
    logic        busy;
  } exp_t;

  exp_t  exp_q[$];
  int    stall_q[$];
  string name_q[$];

  int errors = 0;
  int checks = 0;

  function automatic stim_t base();
    stim_t s;
    s.alusel = 4'b1111; s.insel = 1'b0; s.dsel = 1'b1; s.rfwe = 1'b1;
    s.dmwe = 1'b0; s.mtorf = 1'b0; s.br = 1'b0;
    s.rd1 = '0; s.rd2 = '0; s.simm = '0; s.pcp1 = '0;
    s.rd = 5'd1; s.rt = 5'd2; s.fa = 2'b00; s.fb = 2'b00;
    s.aluoutm = '0; s.resultw = '0;
    return s;
  endfunction

  function automatic exp_t mk(input logic [31:0] alu, input logic [4:0] wreg,
                              input logic rfwe, input logic dmwe, input logic mtorf,
                              input logic bt, input logic [31:0] pcb,
                              input logic [31:0] wdata, input logic busy);
    exp_t e;
    e.alu = alu; e.zero = (alu == 32'd0); e.wreg = wreg; e.rfwe = rfwe;
    e.dmwe = dmwe; e.mtorf = mtorf; e.bt = bt; e.pcb = pcb; e.wdata = wdata;
    e.busy = busy;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    bus.ALUselE = s.alusel; bus.ALUInSelE = s.insel; bus.RFDSelE = s.dsel;
    bus.RFWEE = s.rfwe; bus.DMWEE = s.dmwe; bus.MtoRFSelE = s.mtorf;
    bus.BranchE = s.br; bus.RFRD1E = s.rd1; bus.RFRD2E = s.rd2;
    bus.simmE = s.simm; bus.PCp1E = s.pcp1; bus.rdE = s.rd; bus.rtE = s.rt;
    bus.ForwardAE = s.fa; bus.ForwardBE = s.fb;
    bus.ALUOutM = s.aluoutm; bus.ResultW = s.resultw;
  endtask

  // Issue one instruction, hold it through any stall, advance after completion.
  task automatic run(input stim_t s, input exp_t e, input int stall,
                     input string nm, input logic mutate);
    apply(s);
    exp_q.push_back(e);
    stall_q.push_back(stall);
    name_q.push_back(nm);
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (mutate && k == 1) begin
        bus.ALUOutM = 32'hDEAD_BEEF;
        bus.ResultW = 32'hDEAD_BEEF;
      end
      if (!bus.StallE) break;
    end
    @(posedge CLK);
    #1;
  endtask

  // Driver
  initial begin
    stim_t s;
    apply(base());
    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b0;

    s = base(); s.alusel = 4'b0010; s.insel = 1'b1; s.rd1 = 32'd5; s.simm = 32'hFFFF_FFFF;
    s.rd2 = 32'h11; s.pcp1 = 32'h20; s.rd = 5'd3;
    run(s, mk(32'd4, 5'd3, 1, 0, 0, 0, 32'h1F, 32'h11, 0), 0, "add_imm", 0);

    s = base(); s.alusel = 4'b0110; s.rd1 = 32'd7; s.rd2 = 32'd7; s.br = 1'b1;
    s.pcp1 = 32'h10; s.simm = 32'd3; s.dsel = 1'b0; s.rt = 5'd5; s.rfwe = 1'b0;
    run(s, mk(32'd0, 5'd5, 0, 0, 0, 1, 32'h13, 32'd7, 0), 0, "sub_branch", 0);

    s = base(); s.alusel = 4'b0010; s.fa = 2'b10; s.aluoutm = 32'd9; s.fb = 2'b01;
    s.resultw = 32'd4; s.rd1 = 32'd100; s.rd2 = 32'd200; s.rd = 5'd7;
    run(s, mk(32'd13, 5'd7, 1, 0, 0, 0, 32'd0, 32'd4, 0), 0, "fwd_add", 0);

    s = base(); s.rd1 = 32'hF0F0_1234; s.rd2 = 32'h0FF0_00FF;
    s.alusel = 4'b0000; run(s, mk(32'h00F0_0034, 5'd1, 1, 0, 0, 0, 0, 32'h0FF0_00FF, 0), 0, "and", 0);
    s.alusel = 4'b0001; run(s, mk(32'hFFF0_12FF, 5'd1, 1, 0, 0, 0, 0, 32'h0FF0_00FF, 0), 0, "or", 0);
    s.alusel = 4'b0011; run(s, mk(32'hFF00_12CB, 5'd1, 1, 0, 0, 0, 0, 32'h0FF0_00FF, 0), 0, "xor", 0);
    s.alusel = 4'b0100; run(s, mk(32'h000F_ED00, 5'd1, 1, 0, 0, 0, 0, 32'h0FF0_00FF, 0), 0, "nor", 0);
    s.alusel = 4'b0111; run(s, mk(32'd1, 5'd1, 1, 0, 0, 0, 0, 32'h0FF0_00FF, 0), 0, "slt_neg", 0);

    s = base(); s.alusel = 4'b0111; s.rd1 = 32'd5; s.rd2 = 32'd3; s.br = 1'b1;
    run(s, mk(32'd0, 5'd1, 1, 0, 0, 1, 0, 32'd3, 0), 0, "slt_false", 0);

    s = base(); s.alusel = 4'b1000; s.simm = 32'h100; s.rd2 = 32'h0FF0_00FF;
    run(s, mk(32'hFF00_0FF0, 5'd1, 1, 0, 0, 0, 32'h100, 32'h0FF0_00FF, 0), 0, "sll4", 0);

    s = base(); s.alusel = 4'b0101; s.rd1 = 32'h1234; s.rd2 = 32'h5678;
    run(s, mk(32'd0, 5'd1, 1, 0, 0, 0, 0, 32'h5678, 0), 0, "undef_op", 0);

    s = base(); s.alusel = 4'b0110; s.rd1 = 32'd3; s.rd2 = 32'd5;
    run(s, mk(32'hFFFF_FFFE, 5'd1, 1, 0, 0, 0, 0, 32'd5, 0), 0, "sub_wrap", 0);

    s = base(); s.alusel = 4'b1010; s.rd1 = 32'h0001_0003; s.rd2 = 32'h10; s.rd = 5'd9;
    s.mtorf = 1'b1; s.pcp1 = 32'h40;
    run(s, mk(32'h0010_0030, 5'd9, 1, 0, 1, 0, 32'h40, 32'h10, 1), 33, "mul", 0);

    s = base(); s.alusel = 4'b1010; s.insel = 1'b1; s.rd1 = 32'hFFFF_FFFF;
    s.simm = 32'hFFFF_FFFF; s.rd2 = 32'h77; s.pcp1 = 32'h100;
    run(s, mk(32'd1, 5'd1, 1, 0, 0, 0, 32'hFF, 32'h77, 1), 33, "mul_ones", 0);

    s = base(); s.alusel = 4'b1010; s.rd1 = 32'd0; s.rd2 = 32'h1234; s.br = 1'b1;
    run(s, mk(32'd0, 5'd1, 1, 0, 0, 0, 0, 32'h1234, 1), 33, "mul_zero_nobr", 0);

    s = base(); s.alusel = 4'b1011; s.fa = 2'b10; s.aluoutm = 32'd100; s.rd2 = 32'd7; s.rd = 5'd10;
    run(s, mk(32'd14, 5'd10, 1, 0, 0, 0, 0, 32'd7, 1), 33, "divu_fwd", 1);

    s = base(); s.alusel = 4'b1100; s.rd1 = 32'd100; s.rd2 = 32'd7; s.rfwe = 1'b0;
    s.dmwe = 1'b1; s.dsel = 1'b0; s.rt = 5'd12;
    run(s, mk(32'd2, 5'd12, 0, 1, 0, 0, 0, 32'd7, 1), 33, "remu", 0);

    s = base(); s.alusel = 4'b1011; s.rd1 = 32'h55; s.rd2 = 32'd0;
    run(s, mk(32'hFFFF_FFFF, 5'd1, 1, 0, 0, 0, 0, 32'd0, 1), 33, "divu_by0", 0);
    s.alusel = 4'b1100;
    run(s, mk(32'h55, 5'd1, 1, 0, 0, 0, 0, 32'd0, 1), 33, "remu_by0", 0);

    s = base(); s.alusel = 4'b1100; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'h10;
    run(s, mk(32'hF, 5'd1, 1, 0, 0, 0, 0, 32'h10, 1), 33, "remu_max", 0);

    // Abandon a multiply at BUSY counter 10; its result must never appear.
    s = base(); s.alusel = 4'b1010; s.rd1 = 32'd3; s.rd2 = 32'd5; s.rd = 5'd20;
    apply(s);
    repeat (11) @(posedge CLK);
    #1;
    CLR = 1'b1;
    s = base(); s.alusel = 4'b0010; s.rd1 = 32'd1; s.rd2 = 32'd2;
    apply(s);
    #2;
    CLR = 1'b0;
    run(s, mk(32'd3, 5'd1, 1, 0, 0, 0, 0, 32'd2, 0), 0, "add_after_clr", 0);

    s = base(); s.alusel = 4'b1011; s.rd1 = 32'd100; s.rd2 = 32'd7;
    run(s, mk(32'd14, 5'd1, 1, 0, 0, 0, 0, 32'd7, 1), 33, "divu_after_clr", 0);

    apply(base());
    tb_done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    exp_t  act;
    exp_t  e;
    int    stall_cnt;
    int    stall_exp;
    string nm;
    stall_cnt = 0;
    #2;
    while (1) begin
      @(negedge CLK or posedge CLR);
      if (tb_done) break;
      if (CLR) begin
        stall_cnt = 0;
        if (!CLK) begin
          checks++;
          if (bus.StallE !== 1'b0 || bus.BusyE !== 1'b0 || bus.ALUOutE !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: stall=%b busy=%b alu=%h, want 0 0 0",
                     bus.StallE, bus.BusyE, bus.ALUOutE);
          end
        end
        continue;
      end
      act.alu = bus.ALUOutE; act.zero = bus.ZeroE; act.wreg = bus.WriteRegE;
      act.rfwe = bus.RFWEOutE; act.dmwe = bus.DMWEOutE; act.mtorf = bus.MtoRFSelOutE;
      act.bt = bus.BranchTakenE; act.pcb = bus.PCBranchE; act.wdata = bus.WriteDataE;
      act.busy = bus.BusyE;
      if (bus.StallE === 1'b1) begin
        stall_cnt++;
        checks++;
        if (act.alu !== 32'd0 || act.rfwe !== 1'b0 || act.dmwe !== 1'b0 || act.bt !== 1'b0) begin
          errors++;
          $display("FAIL bubble: alu=%h rfwe=%b dmwe=%b bt=%b, want all 0",
                   act.alu, act.rfwe, act.dmwe, act.bt);
        end
        if (stall_cnt > 40) begin
          $display("FAIL stall_timeout: stalled %0d cycles, limit 40", stall_cnt);
          errors++;
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $fatal(1, "stall timeout");
        end
        continue;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: alu=%h wreg=%0d rfwe=%b, want no output",
                 act.alu, act.wreg, act.rfwe);
        continue;
      end
      e = exp_q.pop_front();
      stall_exp = stall_q.pop_front();
      nm = name_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got alu=%h z=%b wr=%0d we=%b dm=%b m2r=%b bt=%b pcb=%h wd=%h busy=%b; want alu=%h z=%b wr=%0d we=%b dm=%b m2r=%b bt=%b pcb=%h wd=%h busy=%b",
                 nm, act.alu, act.zero, act.wreg, act.rfwe, act.dmwe, act.mtorf, act.bt,
                 act.pcb, act.wdata, act.busy, e.alu, e.zero, e.wreg, e.rfwe, e.dmwe,
                 e.mtorf, e.bt, e.pcb, e.wdata, e.busy);
      end
      checks++;
      if (stall_cnt != stall_exp) begin
        errors++;
        $display("FAIL %s_stall_cycles: got %0d, want %0d", nm, stall_cnt, stall_exp);
      end
      stall_cnt = 0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d never produced, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_stage.md
Name: ex_muldiv_stage

Overview:
- Execute stage: consumes the ID/EX pipeline register outputs and drives the EX/MEM register.
- Contains operand forwarding muxes, a single-cycle ALU, and branch target/condition logic.
- Adds a 32-iteration sequential multiply/divide unit. While it runs, the unit stalls the front end (PC, IF/ID, ID/EX hold) and inserts bubbles downstream.

Parameters:
WIDTH, 32, datapath width; the iterative unit runs WIDTH iterations.

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  asynchronous active-high reset
ALUselE  in  4  op select
ALUInSelE  in  1  1 = B operand is simmE, 0 = forwarded RFRD2E
RFDSelE  in  1  1 = dest is rdE, 0 = dest is rtE
RFWEE, DMWEE, MtoRFSelE, BranchE  in  1 each  control from ID/EX
RFRD1E, RFRD2E, simmE, PCp1E  in  WIDTH each  operands, sign-extended imm, PC+1
rdE, rtE  in  5 each  destination candidates
ForwardAE, ForwardBE  in  2 each  00 reg, 01 ResultW, 10 ALUOutM, 11 = 00
ALUOutM, ResultW  in  WIDTH each  forwarded values
ALUOutE  out  WIDTH  result to EX/MEM
WriteDataE  out  WIDTH  forwarded B register value (store data)
WriteRegE  out  5  destination register
RFWEOutE, DMWEOutE, MtoRFSelOutE  out  1 each  controls to EX/MEM
BranchTakenE  out  1  BranchE & ZeroE
PCBranchE  out  WIDTH  PCp1E + simmE
ZeroE  out  1  ALUOutE == 0
StallE  out  1  hold PC/IF/ID/ID/EX this cycle
BusyE  out  1  FSM not IDLE

Behaviour:
- ALUsel: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT (signed, result 0/1), 1000 SLL by simmE[10:6], 1010 MUL (low WIDTH bits), 1011 DIVU quotient, 1100 REMU remainder.
- Other ALUsel codes: ALUOutE = 0.
- Adds and subtracts wrap modulo 2^WIDTH. No overflow flag.
- Single-cycle ops are combinational; the FSM stays IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE with ALUsel in {1010, 1011, 1100}:
  - StallE = 1 combinationally.
  - Outputs RFWEOutE = DMWEOutE = BranchTakenE = 0 and ALUOutE = 0 (bubble).
  - At the clock edge, latch forwarded A, forwarded B (or simm per ALUInSelE), op, WriteReg, RFWEE, MtoRFSelE, DMWEE.
  - Counter = 0, go to BUSY.
- BUSY:
  - StallE = 1, bubble outputs.
  - One shift-add (MUL) or restoring shift-subtract (DIV/REM) iteration per cycle.
  - Counter increments; at counter = WIDTH-1, go to DONE.
- DONE:
  - StallE = 0.
  - ALUOutE = latched result; WriteRegE and controls come from latched values; ZeroE reflects the result; BranchTakenE = 0.
  - Go to IDLE at the next edge. ID/EX loads the next instruction on that same edge.
- Occupancy: 1 + WIDTH + 1 cycles (34 at WIDTH = 32); the front end is stalled for WIDTH+1 cycles.
- Divide by zero: quotient = all ones, remainder = dividend, same cycle count.
- A muldiv op arriving in the cycle after DONE starts a fresh operation. There are no back-to-back hazards inside the block.
- Forwarded operands are sampled only in the IDLE cycle. Later ALUOutM/ResultW changes do not affect an in-flight op.
- Reset (async, any state, mid-operation included):
  - FSM = IDLE, counter = 0, all latched operands/result/controls = 0.
  - StallE = 0, BusyE = 0; outputs then follow the combinational path.
  - An in-flight op is abandoned, with no writeback.
- WriteDataE is always the forwarded B register value, independent of ALUInSelE.

Test Plan:
1. ADD: RFRD1E=5, simmE=0xFFFFFFFF, ALUInSelE=1 -> ALUOutE=4, ZeroE=0, StallE=0.
2. Branch: ALUsel=SUB, A=B=7, BranchE=1, PCp1E=0x10, simmE=3 -> ZeroE=1, BranchTakenE=1, PCBranchE=0x13.
3. Forwarding: ForwardAE=10, ALUOutM=9, ForwardBE=01, ResultW=4, ADD -> ALUOutE=13, WriteDataE=4.
4. MUL: 0x0001_0003 × 0x0000_0010 -> StallE=1 for 33 cycles, RFWEOutE=0 during busy; DONE cycle ALUOutE=0x0010_0030, RFWEOutE=1, WriteRegE=rdE latched.
5. DIVU 100/7 -> DONE ALUOutE=14; REMU 100/7 -> 2; DIVU x/0 with x=0x55 -> 0xFFFFFFFF; REMU x/0 -> 0x55.
6. Assert CLR at BUSY counter 10 -> next cycle StallE=0, BusyE=0; a following ADD completes normally and no MUL result ever appears.
